draw_map_tiled: RTL

Tile-based successor to the fixed-geometry map painter in the VGA pixel path. Sits between the timing generator and the sprite/overlay stages, converts each pixel's `hcount`/`vcount` into a tile address, reads a run-time writable tile map and colours the pixel from a parameterised palette. Game logic can rewrite tiles at run time through a valid/ready port, for example to remove destroyed walls. A cursor-highlight outline is drawn over one tile. Timing signals are forwarded with the same latency as `rgb_out`.

---
 rtl/draw_map_tiled_if.sv | 15 +
 rtl/draw_map_tiled.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/draw_map_tiled_if.sv
// Tile-write port of draw_map_tiled: valid/ready request plus error pulse.
interface draw_map_tiled_if #(
  parameter int unsigned COL_W = 5,
  parameter int unsigned ROW_W = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [3:0]       wr_tile;
  logic             wr_err;

  modport master (output wr_valid, wr_col, wr_row, wr_tile, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_col, wr_row, wr_tile, output wr_ready, wr_err);
endinterface

// File: rtl/draw_map_tiled.sv
// Tile-map painter: converts hcount/vcount into a tile address, reads a
// run-time writable tile RAM and colours the pixel from a palette, with a
// screen frame and a cursor outline. Three-cycle pixel latency.
module draw_map_tiled #(
  parameter int unsigned   TILE_LOG2    = 5,
  parameter int unsigned   MAP_COLS     = 24,
  parameter int unsigned   MAP_ROWS     = 24,
  parameter int unsigned   MAP_X0       = 0,
  parameter int unsigned   MAP_Y0       = 0,
  parameter int unsigned   H_RES        = 1024,
  parameter int unsigned   V_RES        = 768,
  parameter int unsigned   BORDER_W     = 2,
  parameter logic [191:0]  PALETTE      = {12'h000, 12'h321, 12'hDDD, 12'hBBB,
                                           12'h999, 12'h777, 12'h555, 12'hF0F,
                                           12'h0FF, 12'hFF0, 12'h00F, 12'hF00,
                                           12'h89F, 12'h0A0, 12'h444, 12'hEC1},
  parameter logic [11:0]   BORDER_COLOR = 12'hFFF,
  parameter logic [11:0]   PANEL_COLOR  = 12'h888,
  parameter logic [11:0]   SEL_COLOR    = 12'hC12,
  localparam int unsigned  COL_W        = $clog2(MAP_COLS),
  localparam int unsigned  ROW_W        = $clog2(MAP_ROWS),
  localparam int unsigned  ADDR_W       = $clog2(MAP_COLS*MAP_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  draw_map_tiled_if.slave  wr,
  input  logic             sel_en,
  input  logic [COL_W-1:0] sel_col,
  input  logic [ROW_W-1:0] sel_row,
  output logic             init_done,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out
);

  localparam int unsigned       N       = MAP_COLS * MAP_ROWS;
  localparam logic [11:0]       X0      = 12'(MAP_X0);
  localparam logic [11:0]       Y0      = 12'(MAP_Y0);
  localparam logic [10:0]       MAP_W   = 11'(MAP_COLS << TILE_LOG2);
  localparam logic [10:0]       MAP_H   = 11'(MAP_ROWS << TILE_LOG2);
  localparam logic [10:0]       BW_H    = 11'(BORDER_W);
  localparam logic [9:0]        BW_V    = 10'(BORDER_W);
  localparam logic [10:0]       FRAME_R = 11'(H_RES - BORDER_W);
  localparam logic [9:0]        FRAME_B = 10'(V_RES - BORDER_W);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);
  localparam logic [TILE_LOG2-1:0] OFF_MAX = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_next;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [3:0]        ram_wdata;
  logic [3:0]        mem [N];
  logic [3:0]        rd_tile;
  logic [ADDR_W-1:0] rd_addr;

  logic              wr_fire_c, in_range_c;
  logic [ADDR_W-1:0] wr_addr_c;

  logic [11:0]          dx, dy;
  logic                 in_map_c;

  logic [10:0]          s1_h, s2_h;
  logic [9:0]           s1_v, s2_v;
  logic                 s1_hb, s1_vb, s2_hb, s2_vb;
  logic                 s1_in_map, s2_in_map;
  logic [COL_W-1:0]     s1_col, s1_sel_col;
  logic [ROW_W-1:0]     s1_row, s1_sel_row;
  logic [TILE_LOG2-1:0] s1_ox, s1_oy;
  logic                 s1_sel_en;
  logic                 s2_frame, s2_hit;
  logic [11:0]          rgb_c;

  assign wr_fire_c  = wr.wr_valid && wr.wr_ready;
  assign in_range_c = (32'(wr.wr_col) < MAP_COLS) && (32'(wr.wr_row) < MAP_ROWS);
  assign wr_addr_c  = ADDR_W'(ADDR_W'(wr.wr_row) * ADDR_W'(MAP_COLS) + ADDR_W'(wr.wr_col));
  assign rd_addr    = s1_in_map ? ADDR_W'(ADDR_W'(s1_row) * ADDR_W'(MAP_COLS) + ADDR_W'(s1_col))
                                : '0;

  // Control FSM state, clear counter and write-port handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      wr.wr_ready <= 1'b0;
      wr.wr_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_next;
      wr.wr_ready <= (state_next == RUN);
      wr.wr_err   <= wr_fire_c && !in_range_c;
      init_done <= (state_next == RUN);
    end
  end

  // Next state and RAM write selection: clear sweep, then accepted writes
  always_comb begin
    state_next = state;
    clr_next   = clr_cnt;
    ram_we     = 1'b0;
    ram_waddr  = clr_cnt;
    ram_wdata  = 4'd0;
    case (state)
      CLEAR: begin
        ram_we = 1'b1;
        if (clr_cnt == LAST) begin
          state_next = RUN;
          clr_next   = '0;
        end else begin
          clr_next = clr_cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        if (wr_fire_c && in_range_c) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr_c;
          ram_wdata = wr.wr_tile;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Tile RAM: read-first video port, writes suppressed while in reset
  always_ff @(posedge clk) begin
    if (rst && ram_we) mem[ram_waddr] <= ram_wdata;
    rd_tile <= mem[rd_addr];
  end

  // Map-relative coordinates; the extra top bit flags pixels left/above the origin
  always_comb begin
    dx       = {1'b0, hcount_in} - X0;
    dy       = {2'b0, vcount_in} - Y0;
    in_map_c = !dx[11] && !dy[11] && (dx[10:0] < MAP_W) && (dy[10:0] < MAP_H);
  end

  // Colour priority: blank, frame, cursor outline, tile, panel
  always_comb begin
    rgb_c = PANEL_COLOR;
    if (s2_hb || s2_vb)  rgb_c = 12'h000;
    else if (s2_frame)   rgb_c = BORDER_COLOR;
    else if (s2_hit)     rgb_c = SEL_COLOR;
    else if (s2_in_map)  rgb_c = PALETTE[8'(rd_tile) * 8'd12 +: 12];
  end

  // Three-stage pixel pipeline: S1 decode, S2 RAM read, S3 colour
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_h <= '0; s1_v <= '0; s1_hb <= 1'b0; s1_vb <= 1'b0;
      s1_in_map <= 1'b0; s1_col <= '0; s1_row <= '0; s1_ox <= '0; s1_oy <= '0;
      s1_sel_en <= 1'b0; s1_sel_col <= '0; s1_sel_row <= '0;
      s2_h <= '0; s2_v <= '0; s2_hb <= 1'b0; s2_vb <= 1'b0;
      s2_in_map <= 1'b0; s2_frame <= 1'b0; s2_hit <= 1'b0;
      hcount_out <= '0; vcount_out <= '0; hblnk_out <= 1'b0; vblnk_out <= 1'b0;
      rgb_out <= '0;
    end else begin
      s1_h       <= hcount_in;
      s1_v       <= vcount_in;
      s1_hb      <= hblnk_in;
      s1_vb      <= vblnk_in;
      s1_in_map  <= in_map_c;
      s1_col     <= COL_W'(dx[10:0] >> TILE_LOG2);
      s1_row     <= ROW_W'(dy[10:0] >> TILE_LOG2);
      s1_ox      <= dx[TILE_LOG2-1:0];
      s1_oy      <= dy[TILE_LOG2-1:0];
      s1_sel_en  <= sel_en;
      s1_sel_col <= sel_col;
      s1_sel_row <= sel_row;

      s2_h      <= s1_h;
      s2_v      <= s1_v;
      s2_hb     <= s1_hb;
      s2_vb     <= s1_vb;
      s2_in_map <= s1_in_map;
      s2_frame  <= (s1_h < BW_H) || (s1_h >= FRAME_R) || (s1_v < BW_V) || (s1_v >= FRAME_B);
      s2_hit    <= s1_sel_en && s1_in_map && (s1_col == s1_sel_col) && (s1_row == s1_sel_row)
                   && ((s1_ox == '0) || (s1_ox == OFF_MAX) || (s1_oy == '0) || (s1_oy == OFF_MAX));

      hcount_out <= s2_h;
      vcount_out <= s2_v;
      hblnk_out  <= s2_hb;
      vblnk_out  <= s2_vb;
      rgb_out    <= rgb_c;
    end
  end

endmodule
